// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant + in-order response bus between fetch (master) and imem (slave).
interface fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC, credit-limited imem requests, PC tag queue, instruction FIFO to decode.
// Define FETCH_ALIGN_CHECK_EN to halt fetch and flag o_misaligned on a misaligned redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   fetch_unit_if.master       io_imem,
   input  logic               i_redirect,
   input  logic [31:0]        i_redirect_pc,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [31:0]        o_inst,
   output logic [31:0]        o_pc,
   output logic               o_misaligned
);
   localparam int          AW         = $clog2(DEPTH);
   localparam int          CW         = AW + 1;
   localparam logic [CW:0] P_DEPTH    = DEPTH[CW:0];
   localparam logic [31:0] P_RESET_PC = RESET_PC & 32'hFFFF_FFFC;

   logic [31:0]   r_pc;
   logic          r_halt;
   logic          r_misaligned;
   logic [CW-1:0] r_out;
   logic [CW-1:0] r_drop;
   logic [CW-1:0] r_wptr;
   logic [CW-1:0] r_rptr;
   logic [AW-1:0] r_tag_wptr;
   logic [AW-1:0] r_tag_rptr;
   logic [31:0]   r_fifo_inst [DEPTH];
   logic [31:0]   r_fifo_pc   [DEPTH];
   logic [31:0]   r_tag_pc    [DEPTH];

   logic [CW-1:0] w_count;
   logic [CW:0]   w_credit_used;
   logic          w_req;
   logic          w_gnt;
   logic          w_rsp;
   logic          w_empty;
   logic          w_pop;
   logic          w_push;
   logic [CW-1:0] w_out_next;
   logic [31:0]   w_redirect_pc;
   logic          w_redirect_bad;

   assign w_count       = r_wptr - r_rptr;
   assign w_credit_used = {1'b0, r_out} + {1'b0, w_count};
   // Outstanding plus buffered never exceeds DEPTH, so a response push can never overflow.
   assign w_req         = !r_halt && (w_credit_used < P_DEPTH);
   assign w_gnt         = w_req && io_imem.gnt;
   assign w_rsp         = io_imem.rvalid;
   assign w_empty       = (r_wptr == r_rptr);
   assign w_pop         = !w_empty && i_ready && !i_redirect;
   assign w_push        = w_rsp && (r_drop == '0) && !i_redirect;
   assign w_out_next    = r_out + {{(CW-1){1'b0}}, w_gnt} - {{(CW-1){1'b0}}, w_rsp};
   assign w_redirect_pc = i_redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
   assign w_redirect_bad = (i_redirect_pc[1:0] != 2'b00);
`else
   assign w_redirect_bad = 1'b0;
`endif

   assign io_imem.req  = w_req;
   assign io_imem.addr = r_pc;
   assign o_valid      = !w_empty;
   assign o_inst       = r_fifo_inst[r_rptr[AW-1:0]];
   assign o_pc         = r_fifo_pc[r_rptr[AW-1:0]];
   assign o_misaligned = r_misaligned;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc         <= P_RESET_PC;
         r_halt       <= 1'b0;
         r_misaligned <= 1'b0;
         r_out        <= '0;
         r_drop       <= '0;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_tag_wptr   <= '0;
         r_tag_rptr   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_fifo_inst[i] <= '0;
            r_fifo_pc[i]   <= '0;
            r_tag_pc[i]    <= '0;
         end
      end else begin
         r_out <= w_out_next;
         // The tag queue tracks every issued request, including ones that will be dropped.
         if (w_gnt) begin
            r_tag_pc[r_tag_wptr] <= r_pc;
            r_tag_wptr           <= r_tag_wptr + 1'b1;
         end
         if (w_rsp) begin
            r_tag_rptr <= r_tag_rptr + 1'b1;
         end
         if (i_redirect) begin
            r_pc         <= w_redirect_pc;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_drop       <= w_out_next;
            r_halt       <= w_redirect_bad;
            r_misaligned <= w_redirect_bad;
         end else begin
            if (w_gnt) begin
               r_pc <= r_pc + 32'd4;
            end
            if (w_rsp && (r_drop != '0)) begin
               r_drop <= r_drop - 1'b1;
            end
            if (w_push) begin
               r_fifo_inst[r_wptr[AW-1:0]] <= io_imem.rdata;
               r_fifo_pc[r_wptr[AW-1:0]]   <= r_tag_pc[r_tag_rptr];
               r_wptr                      <= r_wptr + 1'b1;
            end
            if (w_pop) begin
               r_rptr <= r_rptr + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with programmable latency, PC model and decode-side scoreboard.
module tb_fetch_unit;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_inst;
   logic [31:0] o_pc;
   logic        o_misaligned;

   always #5 clk = ~clk;

   fetch_unit_if imem ();

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .io_imem       (imem),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_inst        (o_inst),
      .o_pc          (o_pc),
      .o_misaligned  (o_misaligned)
   );

   typedef struct {
      logic [31:0] rpc;
      int          lat;
      logic [31:0] exp_addr;
      bit          mis;
      int          npops;
   } vec_t;

   int          tests, fails;
   int          cyc, lat, npop, ngnt;
   bit          gnt_en, model_halt, found;
   logic [31:0] model_pc;
   logic [31:0] mq_addr [$];
   int          mq_due  [$];
   logic [31:0] eq      [$];
   logic [31:0] pop_log [$];
   vec_t        vecs [5];

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a ^ 32'hC0DE_0013;
   endfunction

   function automatic logic [31:0] log_at(input int k);
      if (k < pop_log.size()) return pop_log[k];
      return 32'hFFFF_FFFF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sb_pop();
      logic [31:0] e;
      npop++;
      pop_log.push_back(o_pc);
      if (eq.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL sb_unexpected: got pc %h expected no instruction", o_pc);
      end else begin
         e = eq.pop_front();
         check("sb_pc", o_pc, e);
         check("sb_inst", o_inst, mem_data(e));
      end
   endtask

   // Drives memory outputs for the upcoming edge; called just after each edge.
   task automatic mem_setup();
      imem.rvalid = 1'b0;
      imem.rdata  = '0;
      imem.gnt    = gnt_en;
      if (rst_n) begin
         if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem.rvalid = 1'b1;
            imem.rdata  = mem_data(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
         end
         if (model_halt) check("halt_noreq", imem.req, 1'b0);
         else if (imem.req && gnt_en) begin
            check("gnt_addr", imem.addr, model_pc);
            mq_addr.push_back(imem.addr);
            mq_due.push_back(cyc + lat);
            eq.push_back(model_pc);
            model_pc = model_pc + 32'd4;
            ngnt++;
         end
      end
   endtask

   task automatic tick();
      if (rst_n && o_valid && i_ready && !i_redirect) sb_pop();
      @(posedge clk);
      #1;
      cyc++;
      mem_setup();
   endtask

   task automatic redirect(input logic [31:0] pc);
      i_redirect    = 1'b1;
      i_redirect_pc = pc;
      eq.delete();
      model_pc = pc & 32'hFFFF_FFFC;
`ifdef FETCH_ALIGN_CHECK_EN
      model_halt = (pc[1:0] != 2'b00);
`endif
      tick();
      i_redirect = 1'b0;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      i_redirect = 1'b0;
      mq_addr.delete();
      mq_due.delete();
      eq.delete();
      model_pc   = 32'h0;
      model_halt = 1'b0;
      mem_setup();
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_req", imem.req, 1'b1);
      check("rst_addr", imem.addr, 32'h0);
      check("rst_valid", o_valid, 1'b0);
      check("rst_inst", o_inst, 32'h0);
      check("rst_pc", o_pc, 32'h0);
      check("rst_mis", o_misaligned, 1'b0);
      rst_n = 1'b1;
      cyc   = 0;
      npop  = 0;
      ngnt  = 0;
      pop_log.delete();
      mem_setup();
   endtask

   task automatic wait_pops(input int n, input int budget, input string name);
      int b;
      b = 0;
      while (npop < n && b < budget) begin
         tick();
         b++;
      end
      if (npop < n) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got %0d pops expected %0d", name, npop, n);
      end
   endtask

   initial begin
      tests = 0; fails = 0; gnt_en = 1'b1; lat = 1; i_ready = 1'b1;
      i_redirect = 1'b0; i_redirect_pc = '0; cyc = 0; npop = 0; ngnt = 0;
      vecs[0] = '{32'h0000_0100, 1, 32'h0000_0100, 1'b0, 3};
      vecs[1] = '{32'h0000_2000, 2, 32'h0000_2000, 1'b0, 3};
`ifdef FETCH_ALIGN_CHECK_EN
      vecs[2] = '{32'h0000_0103, 1, 32'h0000_0100, 1'b1, 0};
`else
      vecs[2] = '{32'h0000_0103, 1, 32'h0000_0100, 1'b0, 3};
`endif
      vecs[3] = '{32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 1'b0, 4};
      vecs[4] = '{32'h0000_0040, 3, 32'h0000_0040, 1'b0, 3};

      // Startup stream with 1-cycle memory
      do_reset();
      tick(); check("start_valid_c1", o_valid, 1'b0);
      tick(); check("start_valid_c2", o_valid, 1'b1); check("start_pc_c2", o_pc, 32'h0);
      wait_pops(4, 30, "start");
      check("start_seq0", log_at(0), 32'h0);
      check("start_seq1", log_at(1), 32'h4);
      check("start_seq2", log_at(2), 32'h8);
      check("start_seq3", log_at(3), 32'hC);

      // Decode stalled: credits cap requests at DEPTH
      i_ready = 1'b0;
      do_reset();
      repeat (10) tick();
      check("stall_grants", ngnt, DEPTH);
      check("stall_req", imem.req, 1'b0);
      check("stall_valid", o_valid, 1'b1);
      check("stall_pc", o_pc, 32'h0);
      i_ready = 1'b1;
      wait_pops(3, 20, "stall");
      check("stall_seq0", log_at(0), 32'h0);
      check("stall_seq1", log_at(1), 32'h4);
      check("stall_seq2", log_at(2), 32'h8);

      // Redirect while two slow requests are outstanding
      lat = 3;
      do_reset();
      tick(); tick();
      check("lat3_outstanding", ngnt, 2);
      check("lat3_req", imem.req, 1'b0);
      npop = 0; pop_log.delete();
      redirect(32'h0000_0100);
      check("lat3_addr", imem.addr, 32'h0000_0100);
      wait_pops(2, 30, "lat3");
      check("lat3_seq0", log_at(0), 32'h0000_0100);
      check("lat3_seq1", log_at(1), 32'h0000_0104);

      // Redirect coinciding with a pop and an arriving response
      lat = 1; found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (o_valid && imem.rvalid) found = 1'b1;
         else tick();
      end
      check("conc_found", found, 1'b1);
      npop = 0; pop_log.delete();
      redirect(32'h0000_0300);
      check("conc_valid", o_valid, 1'b0);
      wait_pops(2, 30, "conc");
      check("conc_seq0", log_at(0), 32'h0000_0300);
      check("conc_seq1", log_at(1), 32'h0000_0304);

      // Table of redirect targets
      for (int v = 0; v < 5; v++) begin
         lat = vecs[v].lat;
         npop = 0; pop_log.delete();
         redirect(vecs[v].rpc);
         check("vec_valid", o_valid, 1'b0);
         check("vec_mis", o_misaligned, vecs[v].mis);
         if (vecs[v].mis) begin
            check("vec_req", imem.req, 1'b0);
            repeat (5) tick();
            check("vec_halt_valid", o_valid, 1'b0);
         end else begin
            check("vec_addr", imem.addr, vecs[v].exp_addr);
            wait_pops(vecs[v].npops, 40, "vec");
            check("vec_first_pc", log_at(0), vecs[v].exp_addr);
         end
      end

      // Address wrap at the top of the address space
      lat = 1;
      redirect(32'hFFFF_FFFC);
      check("wrap_addr0", imem.addr, 32'hFFFF_FFFC);
      for (int k = 0; k < 10 && model_pc == 32'hFFFF_FFFC; k++) tick();
      tick();
      check("wrap_addr1", imem.addr, 32'h0000_0000);

`ifdef FETCH_ALIGN_CHECK_EN
      redirect(32'h0000_0102);
      check("align_mis_set", o_misaligned, 1'b1);
      check("align_req_off", imem.req, 1'b0);
      repeat (4) tick();
      check("align_req_held", imem.req, 1'b0);
      npop = 0; pop_log.delete();
      redirect(32'h0000_0200);
      check("align_mis_clr", o_misaligned, 1'b0);
      check("align_addr", imem.addr, 32'h0000_0200);
      wait_pops(1, 30, "align");
      check("align_first_pc", log_at(0), 32'h0000_0200);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
